multicycle_ctrl: RTL

Multicycle control unit for the ARM-subset processor. It replaces the single-cycle control path with a state machine that reuses one ALU and one unified memory port across several cycles per instruction. It drives the PC, instruction register, register file, memory and ALU-mux enables. It also holds the NZCV flag register and the conditional-execution gate.

---
 rtl/multicycle_ctrl.sv | 259 +++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle control FSM for the ARM-subset core.
// Sequences one ALU and one memory port per instruction; owns NZCV and the cond gate.
//
// Ports:
//   clk, reset        rising-edge clock, async active-high reset
//   Instr[31:12]      instruction register bits (valid from DECODE)
//   ALUFlags          NZCV from the ALU in the current cycle
//   PCWrite, IRWrite, RegWrite, MemWrite   write strobes
//   AdrSrc, ResultSrc, ALUSrcA, ALUSrcB,
//   ImmSrc, RegSrc, ALUControl             datapath mux/op selects
//   Flags             registered NZCV for trace
module multicycle_ctrl (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:12] Instr,
  input  logic [3:0]   ALUFlags,
  output logic         PCWrite,
  output logic         AdrSrc,
  output logic         MemWrite,
  output logic         IRWrite,
  output logic         RegWrite,
  output logic [1:0]   ResultSrc,
  output logic         ALUSrcA,
  output logic [1:0]   ALUSrcB,
  output logic [1:0]   ImmSrc,
  output logic [1:0]   RegSrc,
  output logic [3:0]   ALUControl,
  output logic [3:0]   Flags
);

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMRD,
    MEMWB,
    MEMWR,
    EXECR,
    EXECI,
    ALUWB,
    BRANCH
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_ORR = 4'b0011;
  localparam logic [3:0] ALU_EOR = 4'b0100;
  localparam logic [3:0] ALU_MOV = 4'b0101;

  localparam logic [3:0] CMD_CMP = 4'b1010;

  state_t state;
  state_t next;

  logic [3:0] flags;
  logic       condex;
  logic       condpass;

  logic [3:0] cond;
  logic [1:0] op;
  logic [3:0] cmd;
  logic       sbit;
  logic       ibit;
  logic       lbit;
  logic [3:0] aluop;
  logic       is_exec;
  logic       arith;

  // Raw strobes before the reset override.
  logic       pcw;
  logic       irw;
  logic       rgw;
  logic       mw;

  // Register-specifier bits are decoded in the datapath, not here.
  logic       unused_instr;

  assign cond = Instr[31:28];
  assign op   = Instr[27:26];
  assign ibit = Instr[25];
  assign cmd  = Instr[24:21];
  assign sbit = Instr[20];
  assign lbit = Instr[20];

  assign unused_instr = ^Instr[19:12];

  assign is_exec = (state == EXECR) || (state == EXECI);

  // Data-processing opcode to ALU operation.
  always_comb begin
    aluop = ALU_ADD;
    case (cmd)
      4'b0100: aluop = ALU_ADD;
      4'b0010: aluop = ALU_SUB;
      4'b1010: aluop = ALU_SUB;
      4'b0000: aluop = ALU_AND;
      4'b1100: aluop = ALU_ORR;
      4'b0001: aluop = ALU_EOR;
      4'b1101: aluop = ALU_MOV;
      default: aluop = ALU_ADD;
    endcase
  end

  // Only arithmetic ops produce meaningful carry/overflow.
  assign arith = (aluop == ALU_ADD) || (aluop == ALU_SUB);

  // ARM condition codes against the registered flags.
  always_comb begin
    logic n, z, c, v;
    n = flags[3];
    z = flags[2];
    c = flags[1];
    v = flags[0];
    condpass = 1'b0;
    unique case (cond)
      4'b0000: condpass = z;
      4'b0001: condpass = ~z;
      4'b0010: condpass = c;
      4'b0011: condpass = ~c;
      4'b0100: condpass = n;
      4'b0101: condpass = ~n;
      4'b0110: condpass = v;
      4'b0111: condpass = ~v;
      4'b1000: condpass = c & ~z;
      4'b1001: condpass = ~c | z;
      4'b1010: condpass = (n == v);
      4'b1011: condpass = (n != v);
      4'b1100: condpass = ~z & (n == v);
      4'b1101: condpass = z | (n != v);
      4'b1110: condpass = 1'b1;
      4'b1111: condpass = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FETCH;
    end else begin
      state <= next;
    end
  end

  // The gate is sampled once per instruction, while the IR is stable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      condex <= 1'b0;
    end else if (state == DECODE) begin
      condex <= condpass;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags <= 4'b0000;
    end else if (is_exec && sbit && condex) begin
      flags[3:2] <= ALUFlags[3:2];
      if (arith) begin
        flags[1:0] <= ALUFlags[1:0];
      end
    end
  end

  always_comb begin
    next = FETCH;
    unique case (state)
      FETCH:  next = DECODE;
      DECODE: begin
        unique case (1'b1)
          (op == 2'b01): next = MEMADR;
          (op == 2'b00): next = ibit ? EXECI : EXECR;
          (op == 2'b10): next = BRANCH;
          (op == 2'b11): next = FETCH;
        endcase
      end
      MEMADR: next = lbit ? MEMRD : MEMWR;
      MEMRD:  next = MEMWB;
      MEMWB:  next = FETCH;
      MEMWR:  next = FETCH;
      EXECR:  next = ALUWB;
      EXECI:  next = ALUWB;
      ALUWB:  next = FETCH;
      BRANCH: next = FETCH;
      default: next = FETCH;
    endcase
  end

  always_comb begin
    pcw        = 1'b0;
    irw        = 1'b0;
    rgw        = 1'b0;
    mw         = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ImmSrc     = 2'b00;
    RegSrc     = 2'b00;
    ALUControl = ALU_ADD;
    unique case (state)
      FETCH: begin
        irw       = 1'b1;
        pcw       = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      DECODE: begin
        // Second PC+4 makes R15 read as PC+8.
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      MEMADR: begin
        ALUSrcB = 2'b01;
        ImmSrc  = 2'b01;
      end
      MEMRD: begin
        AdrSrc = 1'b1;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        rgw       = condex;
      end
      MEMWR: begin
        AdrSrc = 1'b1;
        RegSrc = 2'b10;
        mw     = condex;
      end
      EXECR: begin
        ALUControl = aluop;
      end
      EXECI: begin
        ALUSrcB    = 2'b01;
        ALUControl = aluop;
      end
      ALUWB: begin
        rgw = condex & (cmd != CMD_CMP);
      end
      BRANCH: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b01;
        ImmSrc    = 2'b10;
        ResultSrc = 2'b10;
        pcw       = condex;
      end
      default: ;
    endcase
  end

  // Strobes die with reset, independent of the clock.
  assign PCWrite  = pcw & ~reset;
  assign IRWrite  = irw & ~reset;
  assign RegWrite = rgw & ~reset;
  assign MemWrite = mw & ~reset;

  assign Flags = flags;

endmodule
